// File: rtl/eth_stats_drain_arbiter.sv
// Round-robin drain controller: pops one record at a time from non-empty stats collector
// FIFOs and presents it on a single valid/ready stream. Define STATS_DRAIN_COUNT_EN for per-port counters.
module eth_stats_drain_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 448,
  parameter int TIMEOUT    = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic [NUM_PORTS-1:0]            fifo_empty,
  output logic [NUM_PORTS-1:0]            fifo_pop,
  input  logic [NUM_PORTS-1:0]            fifo_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic [$clog2(NUM_PORTS)-1:0]    m_src,
  output logic                            busy,
`ifdef STATS_DRAIN_COUNT_EN
  input  logic                            count_clr,
  output logic [NUM_PORTS*32-1:0]         drain_count,
`endif
  output logic                            timeout_p
);

  localparam int PTR_W = $clog2(NUM_PORTS);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, POP, WAIT, OUT} state_t;

  state_t               state, state_nxt;
  logic [PTR_W-1:0]     grant;
  logic [PTR_W-1:0]     pick;
  logic [PTR_W-1:0]     idx;
  logic                 found;
  logic [CNT_W-1:0]     wait_cnt;
  logic                 grant_go;
  logic                 capture;
  logic                 expire;
  logic [NUM_PORTS-1:0] pop_nxt;
  logic                 valid_nxt;
  logic                 busy_nxt;

  // grant doubles as the round-robin pointer: the search starts one past the last granted port
  always_comb begin
    pick  = grant;
    found = 1'b0;
    idx   = grant;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (idx == PTR_W'(NUM_PORTS - 1)) ? '0 : idx + PTR_W'(1);
      if (!found && !fifo_empty[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign grant_go = enable && found;
  assign capture  = (state == WAIT) && fifo_valid[grant];
  assign expire   = (state == WAIT) && !fifo_valid[grant] && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= PTR_W'(NUM_PORTS - 1);
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_go) grant <= pick;
      if (state == WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
      else               wait_cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_go) state_nxt = POP;
      POP:     state_nxt = WAIT;
      WAIT: begin
        if (capture)     state_nxt = OUT;
        else if (expire) state_nxt = IDLE;
      end
      OUT:     if (m_valid && m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop_nxt   = '0;
    valid_nxt = (state_nxt == OUT);
    busy_nxt  = (state_nxt != IDLE);
    if (state == IDLE && grant_go) pop_nxt[pick] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_pop  <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_src     <= '0;
      busy      <= 1'b0;
      timeout_p <= 1'b0;
    end else begin
      fifo_pop  <= pop_nxt;
      m_valid   <= valid_nxt;
      busy      <= busy_nxt;
      timeout_p <= expire;
      if (capture) begin
        m_data <= fifo_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        m_src  <= grant;
      end
    end
  end

`ifdef STATS_DRAIN_COUNT_EN
  // A clear in the same cycle as a handshake wins, so the delivered record is not counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_count <= '0;
    end else if (count_clr) begin
      drain_count <= '0;
    end else if (m_valid && m_ready) begin
      drain_count[int'(m_src)*32 +: 32] <= drain_count[int'(m_src)*32 +: 32] + 32'd1;
    end
  end
`else
  // Without counters the delivered stream carries no extra bookkeeping.
`endif

endmodule

// File: tb/tb_eth_stats_drain_arbiter.sv
// Scoreboard testbench for eth_stats_drain_arbiter: FIFO responders with 1-cycle read latency,
// expected records queued when loaded and compared whenever m_valid is observed.
module tb_eth_stats_drain_arbiter;

  localparam int NP = 4;
  localparam int DW = 448;
  localparam int TO = 16;

  logic              clk        = 1'b0;
  logic              rst_n      = 1'b1;
  logic              enable     = 1'b0;
  logic              m_ready    = 1'b0;
  logic [NP-1:0]     fifo_empty = '1;
  logic [NP-1:0]     fifo_valid = '0;
  logic [NP*DW-1:0]  fifo_data  = '0;
  logic [NP-1:0]     fifo_pop;
  logic              m_valid;
  logic [DW-1:0]     m_data;
  logic [1:0]        m_src;
  logic              busy;
  logic              timeout_p;
`ifdef STATS_DRAIN_COUNT_EN
  logic              count_clr = 1'b0;
  logic [NP*32-1:0]  drain_count;
`endif

  eth_stats_drain_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_pop   (fifo_pop),
    .fifo_valid (fifo_valid),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_src      (m_src),
    .busy       (busy),
`ifdef STATS_DRAIN_COUNT_EN
    .count_clr  (count_clr),
    .drain_count(drain_count),
`endif
    .timeout_p  (timeout_p)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    src;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] mem [NP][32];
  int            wr_ptr [NP] = '{default: 0};
  int            rd_ptr [NP] = '{default: 0};
  logic [NP-1:0] mute = '0;
  logic [NP-1:0] pend = '0;
  logic [DW-1:0] pend_data [NP];
  logic          prev_valid = 1'b0;
  logic          prev_hs = 1'b0;

  task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [DW-1:0] mkData(input int port);
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = $urandom;
    d[7:0] = 8'(port);
    return d;
  endfunction

  task automatic applyStimulus(input int port, input logic [DW-1:0] data, input bit expect_out);
    mem[port][wr_ptr[port] % 32] = data;
    wr_ptr[port]++;
    if (expect_out) sb.push_back(exp_t'{src: 2'(port), data: data});
  endtask

  task automatic waitPop(input string tag, input logic [NP-1:0] exp_pop);
    for (int i = 0; i < 40; i++) begin
      if (fifo_pop != '0) break;
      @(negedge clk);
    end
    checkOutput(tag, DW'(fifo_pop), DW'(exp_pop));
  endtask

  task automatic waitValid(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (m_valid) break;
      @(negedge clk);
    end
    checkOutput(tag, DW'(m_valid), DW'(1));
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) break;
    end
    checkOutput({tag, "_busy"}, DW'(busy), DW'(0));
    checkOutput({tag, "_sb"}, DW'(sb.size()), DW'(0));
  endtask

  // FIFO responders: a pop seen in the POP cycle returns data one cycle later unless muted
  always @(negedge clk) begin
    if (!rst_n) begin
      fifo_valid = '0;
      pend       = '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        fifo_valid[p] = pend[p];
        if (pend[p]) fifo_data[p*DW +: DW] = pend_data[p];
      end
      pend = '0;
      for (int p = 0; p < NP; p++) begin
        if (fifo_pop[p] && rd_ptr[p] != wr_ptr[p]) begin
          pend[p]      = !mute[p];
          pend_data[p] = mem[p][rd_ptr[p] % 32];
          rd_ptr[p]++;
        end
      end
    end
    for (int p = 0; p < NP; p++) fifo_empty[p] = (rd_ptr[p] == wr_ptr[p]);
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (prev_valid && !prev_hs) checkOutput("hold_valid", DW'(m_valid), DW'(1));
      if (m_valid) begin
        if (sb.size() == 0) begin
          checkOutput("out_unexpected", DW'(m_valid), DW'(0));
        end else begin
          checkOutput("out_src", DW'(m_src), DW'(sb[0].src));
          checkOutput("out_data", m_data, sb[0].data);
          if (m_ready) void'(sb.pop_front());
        end
        checkOutput("pop_in_out", DW'(fifo_pop), DW'(0));
      end
      if (fifo_pop != '0) checkOutput("pop_onehot", DW'($onehot(fifo_pop)), DW'(1));
      prev_valid = m_valid;
      prev_hs    = m_valid && m_ready;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    int            pops;
    int            k;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", DW'(m_valid), DW'(0));
    checkOutput("rst_pop", DW'(fifo_pop), DW'(0));
    checkOutput("rst_busy", DW'(busy), DW'(0));
    checkOutput("rst_timeout", DW'(timeout_p), DW'(0));
    checkOutput("rst_src", DW'(m_src), DW'(0));
    checkOutput("rst_data", m_data, DW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1; enable = 1'b1; m_ready = 1'b1;

    $display("[TB] single port");
    @(posedge clk); #1;
    applyStimulus(2, DW'(448'hA5), 1'b1);
    waitPop("single_pop", 4'b0100);
    @(negedge clk);
    checkOutput("single_pop_once", DW'(fifo_pop), DW'(0));
    checkOutput("single_lat_t2", DW'(m_valid), DW'(0));
    @(negedge clk);
    checkOutput("single_lat_t3", DW'(m_valid), DW'(1));
    waitIdle("single");

    $display("[TB] backpressure");
    @(posedge clk); #1;
    m_ready = 1'b0;
    applyStimulus(0, mkData(0), 1'b1);
    waitValid("bp_valid");
    @(posedge clk); #1;
    applyStimulus(1, mkData(1), 1'b1);
    pops = 0;
    repeat (10) begin
      @(negedge clk);
      if (fifo_pop != '0) pops++;
    end
    checkOutput("bp_no_pop", DW'(pops), DW'(0));
    checkOutput("bp_hold", DW'(m_valid), DW'(1));
    @(posedge clk); #1;
    m_ready = 1'b1;
    waitIdle("bp");

    $display("[TB] timeout");
    @(posedge clk); #1;
    mute[1] = 1'b1;
    applyStimulus(1, mkData(1), 1'b0);
    waitPop("to_pop", 4'b0010);
    @(posedge clk); #1;
    applyStimulus(2, mkData(2), 1'b1);
    applyStimulus(0, mkData(0), 1'b1);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) checkOutput("to_busy", DW'(busy), DW'(1));
      if (timeout_p) begin
        k = i;
        break;
      end
    end
    checkOutput("to_latency", DW'(k), DW'(TO + 1));
    checkOutput("to_no_valid", DW'(m_valid), DW'(0));
    @(negedge clk);
    checkOutput("to_pulse", DW'(timeout_p), DW'(0));
    waitPop("to_next", 4'b0100);
    mute[1] = 1'b0;
    waitIdle("to");

    $display("[TB] enable drop");
    @(posedge clk); #1;
    m_ready = 1'b0;
    applyStimulus(1, mkData(1), 1'b1);
    waitValid("en_valid");
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 m_ready = 1'b1;
    waitIdle("en_drain");
    @(posedge clk); #1;
    applyStimulus(3, mkData(3), 1'b1);
    pops = 0;
    repeat (8) begin
      @(negedge clk);
      if (fifo_pop != '0) pops++;
    end
    checkOutput("en_blocked", DW'(pops), DW'(0));
    checkOutput("en_idle", DW'(busy), DW'(0));
    @(posedge clk); #1;
    enable = 1'b1;
    waitPop("en_resume", 4'b1000);
    waitIdle("en");

    $display("[TB] reset mid-OUT");
    @(posedge clk); #1;
    m_ready = 1'b0;
    applyStimulus(3, mkData(3), 1'b1);
    waitValid("rm_valid");
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rm_valid_low", DW'(m_valid), DW'(0));
    checkOutput("rm_pop_low", DW'(fifo_pop), DW'(0));
    checkOutput("rm_busy_low", DW'(busy), DW'(0));
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_ready = 1'b1;

    $display("[TB] round robin");
    @(posedge clk); #1;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) applyStimulus(p, mkData(p), 1'b1);
    waitIdle("rr");

`ifdef STATS_DRAIN_COUNT_EN
    $display("[TB] counters");
    for (int p = 0; p < NP; p++) checkOutput("cnt_rr", DW'(drain_count[p*32 +: 32]), DW'(2));
    @(posedge clk); #1 count_clr = 1'b1;
    @(posedge clk); #1 count_clr = 1'b0;
    @(negedge clk);
    checkOutput("cnt_clr", DW'(drain_count[3*32 +: 32]), DW'(0));
    @(posedge clk); #1;
    for (int n = 0; n < 5; n++) applyStimulus(3, mkData(3), 1'b1);
    waitIdle("cnt_five");
    checkOutput("cnt_five", DW'(drain_count[3*32 +: 32]), DW'(5));
    @(posedge clk); #1;
    m_ready = 1'b0;
    applyStimulus(3, mkData(3), 1'b1);
    waitValid("cnt_hs_valid");
    @(posedge clk); #1;
    count_clr = 1'b1;
    m_ready   = 1'b1;
    @(posedge clk); #1 count_clr = 1'b0;
    @(negedge clk);
    checkOutput("cnt_clr_wins", DW'(drain_count[3*32 +: 32]), DW'(0));
    waitIdle("cnt");
`endif

    waitIdle("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
